kbd_mmio: RTL and testbench

KBD_MMIO -- requirements
Module: kbd_mmio

---
 rtl/kbd_mmio.sv | 196 +++++++++++++++++++
 tb/tb_kbd_mmio.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/kbd_mmio.sv
// PS/2 keyboard receiver feeding a scan-code FIFO, exposed to the CPU as two MMIO words.
// DATA (offset 0) pops on an effective read; STATUS (offset 1) holds count plus sticky err/ovf.
module kbd_mmio #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        sel,
    input  logic        rd,
    input  logic        wr,
    input  logic        hold,
    input  logic        addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} rxState_t;

    logic [1:0]    clkSync_q;
    logic [1:0]    dataSync_q;
    logic          clkPrev_q;
    logic          fallEdge;
    logic          rxBit;

    rxState_t      state_q;
    logic [3:0]    bitCnt_q;
    logic [9:0]    shift_q;
    logic [TW-1:0] tmo_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          err_q;
    logic          err_d;
    logic          irq_q;

    logic          frameOk;
    logic          push;
    logic          pop;
    logic          accepted;
    logic          full;
    logic          nonEmpty;
    logic          timeout;
    logic          access;
    logic [3:0]    countNib;
    logic          unusedWdata;

    assign unusedWdata = ^{wdata[31:3], wdata[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
            clkPrev_q  <= 1'b1;
        end else begin
            clkSync_q  <= {clkSync_q[0], ps2_clk};
            dataSync_q <= {dataSync_q[0], ps2_data};
            clkPrev_q  <= clkSync_q[1];
        end
    end

    assign fallEdge = clkPrev_q & ~clkSync_q[1];
    assign rxBit    = dataSync_q[1];

    assign timeout = (state_q == SHIFT) && !fallEdge && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // Bits arrive LSB first and shift in from the top, so after ten samples
    // shift_q holds {stop, parity, data[7:0]}.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bitCnt_q <= 4'd0;
            shift_q  <= 10'd0;
            tmo_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tmo_q <= '0;
                    if (fallEdge && !rxBit) begin
                        state_q  <= SHIFT;
                        bitCnt_q <= 4'd0;
                    end
                end
                SHIFT: begin
                    if (fallEdge) begin
                        shift_q  <= {rxBit, shift_q[9:1]};
                        bitCnt_q <= bitCnt_q + 4'd1;
                        tmo_q    <= '0;
                        if (bitCnt_q == 4'd9) begin
                            state_q <= CHECK;
                        end
                    end else if (timeout) begin
                        state_q <= IDLE;
                        tmo_q   <= '0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                CHECK: begin
                    state_q  <= IDLE;
                    bitCnt_q <= 4'd0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign frameOk  = shift_q[9] & (^shift_q[8:0]);
    assign push     = (state_q == CHECK) && frameOk;
    assign access   = sel & ~hold;
    assign nonEmpty = (count_q != '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign pop      = access & rd & ~addr & nonEmpty;
    assign accepted = push & (~full | pop);

    // A simultaneous push and pop on a full FIFO writes the slot being vacated.
    always_comb begin
        count_d = count_q;
        if (accepted && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!accepted && pop) begin
            count_d = count_q - CW'(1);
        end

        ovf_d = ovf_q;
        if (push && full && !pop) begin
            ovf_d = 1'b1;
        end else if (access && wr && addr && wdata[1]) begin
            ovf_d = 1'b0;
        end

        err_d = err_q;
        if (((state_q == CHECK) && !frameOk) || timeout) begin
            err_d = 1'b1;
        end else if (access && wr && addr && wdata[2]) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            if (accepted) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            irq_q   <= nonEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accepted) begin
            mem_q[wrPtr_q] <= shift_q[7:0];
        end
    end

    assign countNib = 4'(count_q);

    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            if (!addr) begin
                if (nonEmpty) begin
                    rdata = {24'd0, mem_q[rdPtr_q]};
                end
            end else begin
                rdata = {24'd0, countNib, 1'b0, err_q, ovf_q, nonEmpty};
            end
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_kbd_mmio.sv
// Scoreboard bench for kbd_mmio: reads queue {irq, rdata} expectations that a
// negedge monitor pops and compares whenever an effective CPU read is presented.
module tb_kbd_mmio;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        sel = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic        hold = 1'b0;
    logic        addr = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;

    int testsRun = 0;
    int failures = 0;
    logic [32:0] expQ[$];
    string       nameQ[$];

    kbd_mmio #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .sel(sel), .rd(rd), .wr(wr), .hold(hold), .addr(addr),
        .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [32:0] actual, input logic [32:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got irq/rdata %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every effective read outside reset consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && sel && rd && !hold) begin
            if (expQ.size() == 0) begin
                testsRun++;
                failures++;
                $display("[TB] FAIL unexpected read: got %h, expected none queued", {irq, rdata});
            end else begin
                checkOutput(nameQ.pop_front(), {irq, rdata}, expQ.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic w, input logic a,
                                 input logic [31:0] wd, input logic h, input int cycles);
        sel = s; rd = r; wr = w; addr = a; wdata = wd; hold = h;
        tick(cycles);
        sel = 0; rd = 0; wr = 0; addr = 0; wdata = 32'd0; hold = 0;
    endtask

    task automatic cpuRead(input logic a, input logic [32:0] exp, input string name);
        expQ.push_back(exp);
        nameQ.push_back(name);
        applyStimulus(1'b1, 1'b1, 1'b0, a, 32'd0, 1'b0, 1);
        tick(1);
    endtask

    task automatic cpuWrite(input logic a, input logic [31:0] wd);
        applyStimulus(1'b1, 1'b0, 1'b1, a, wd, 1'b0, 1);
        tick(1);
    endtask

    // atCheck: 1 = DATA read in the CHECK cycle, 2 = STATUS write 0x6 in the CHECK cycle.
    // CHECK falls three clocks after the stop-bit falling edge is driven (2 sync flops + edge detect).
    task automatic sendFrame(input logic [7:0] d, input logic flipParity, input int nBits,
                             input int atCheck, input logic [32:0] checkExp, input string name);
        logic [10:0] bits;
        bits = {1'b1, (~^d) ^ flipParity, d, 1'b0};
        for (int i = 0; i < nBits; i++) begin
            ps2_data = bits[i];
            tick(4);
            ps2_clk = 1'b0;
            if (i == 10 && atCheck != 0) begin
                tick(3);
                if (atCheck == 1) begin
                    expQ.push_back(checkExp);
                    nameQ.push_back(name);
                    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1);
                end else begin
                    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h6, 1'b0, 1);
                end
                tick(4);
            end else begin
                tick(8);
            end
            ps2_clk = 1'b1;
            tick(4);
        end
        ps2_data = 1'b1;
    endtask

    task automatic sendByte(input logic [7:0] d);
        sendFrame(d, 1'b0, 11, 0, 33'd0, "");
    endtask

    task automatic waitIrq(input int limit, input string name);
        int n = 0;
        while (irq !== 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
        checkOutput(name, {32'd0, irq}, 33'd1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset, including a CPU write and read issued while reset is held.
        tick(2);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1);
        tick(2);
        rst = 1'b0;
        tick(1);
        cpuRead(1'b1, {1'b0, 32'h00}, "reset STATUS");
        cpuRead(1'b0, {1'b0, 32'h00}, "reset DATA empty");

        // Single good frame, then drain it.
        sendByte(8'h1C);
        waitIrq(20, "irq after 0x1C");
        cpuRead(1'b1, {1'b1, 32'h11}, "STATUS after 0x1C");
        cpuRead(1'b0, {1'b1, 32'h1C}, "DATA 0x1C");
        cpuRead(1'b1, {1'b0, 32'h00}, "STATUS after pop");

        // Bad parity sets err; a clear in the same cycle as a new error loses.
        sendFrame(8'h1C, 1'b1, 11, 0, 33'd0, "");
        tick(5);
        cpuRead(1'b1, {1'b0, 32'h04}, "STATUS bad parity");
        sendFrame(8'h1C, 1'b1, 11, 2, 33'd0, "");
        tick(2);
        cpuRead(1'b1, {1'b0, 32'h04}, "err set beats clear");
        cpuWrite(1'b1, 32'h4);
        cpuRead(1'b1, {1'b0, 32'h00}, "err cleared");

        // Nine frames into an eight-deep FIFO: last one dropped with ovf.
        for (int i = 1; i <= 9; i++) sendByte(8'(i));
        cpuRead(1'b1, {1'b1, 32'h83}, "STATUS overflow");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h6, 1'b1, 3);
        cpuRead(1'b1, {1'b1, 32'h83}, "held write no effect");
        for (int i = 1; i <= 8; i++) cpuRead(1'b0, {1'b1, 32'(i)}, "DATA drain overflow");
        cpuRead(1'b1, {1'b0, 32'h02}, "STATUS ovf sticky");
        cpuWrite(1'b1, 32'h2);
        cpuRead(1'b1, {1'b0, 32'h00}, "ovf cleared");

        // Full FIFO with push and pop in the same cycle.
        for (int i = 0; i < 8; i++) sendByte(8'h10 + 8'(i));
        cpuRead(1'b1, {1'b1, 32'h81}, "STATUS full");
        sendFrame(8'h18, 1'b0, 11, 1, {1'b1, 32'h10}, "pop at CHECK");
        cpuRead(1'b1, {1'b1, 32'h81}, "full push+pop keeps count");
        for (int i = 1; i <= 8; i++) cpuRead(1'b0, {1'b1, 32'h10 + 32'(i)}, "DATA tail order");
        cpuRead(1'b1, {1'b0, 32'h00}, "STATUS after full drain");

        // Held DATA read pops exactly once.
        sendByte(8'hA1);
        sendByte(8'hA2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 3);
        cpuRead(1'b0, {1'b1, 32'hA1}, "DATA after hold");
        cpuRead(1'b1, {1'b1, 32'h11}, "one pop after hold");
        cpuRead(1'b0, {1'b1, 32'hA2}, "DATA second");
        cpuRead(1'b1, {1'b0, 32'h00}, "STATUS after hold test");

        // Partial frame abandoned by timeout, then a clean frame.
        sendFrame(8'h55, 1'b0, 5, 0, 33'd0, "");
        tick(TIMEOUT + 20);
        cpuRead(1'b1, {1'b0, 32'h04}, "STATUS timeout err");
        cpuWrite(1'b1, 32'h4);
        sendByte(8'h5A);
        cpuRead(1'b1, {1'b1, 32'h11}, "STATUS after timeout frame");
        cpuRead(1'b0, {1'b1, 32'h5A}, "DATA after timeout");

        // Reset mid-frame, then a frame right after reset.
        sendFrame(8'h77, 1'b0, 6, 0, 33'd0, "");
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        cpuRead(1'b1, {1'b0, 32'h00}, "STATUS after mid-frame reset");
        sendByte(8'h33);
        cpuRead(1'b1, {1'b1, 32'h11}, "STATUS after reset frame");

        // sel=0 gives zero and no pop; DATA writes are ignored.
        sel = 1'b0; rd = 1'b1; addr = 1'b0;
        @(negedge clk);
        checkOutput("sel0 rdata", {irq, rdata}, {1'b1, 32'h0});
        tick(1);
        rd = 1'b0;
        cpuWrite(1'b0, 32'hFFFF_FFFF);
        cpuRead(1'b1, {1'b1, 32'h11}, "no pop with sel0");
        cpuRead(1'b0, {1'b1, 32'h33}, "DATA 0x33");

        tick(5);
        checkOutput("scoreboard drained", 33'(expQ.size()), 33'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end
endmodule
